// File: rtl/seg7_scan_mux_if.sv
// Host-side bus of the 7-segment scanner: load strobe, display data and status flags.
interface seg7_scan_mux_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic                  lz_blank;
    logic                  blink_en;
    logic                  update_pending;
    logic                  frame_tick;

    modport master (
        output load, value, dp, lz_blank, blink_en,
        input  update_pending, frame_tick
    );

    modport slave (
        input  load, value, dp, lz_blank, blink_en,
        output update_pending, frame_tick
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver with dead time, leading-zero blanking,
// frame-locked blink and a double-buffered update that only commits at frame end.
module seg7_scan_mux #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 4000,
    parameter int DEAD           = 16,
    parameter int BLINK_FRAMES   = 256,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    seg7_scan_mux_if.slave    bus,
    output logic [6:0]        seg,
    output logic              seg_dp,
    output logic [DIGITS-1:0] dig
);

    localparam int POS_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(SCAN_DIV - 1);
    localparam logic [POS_W-1:0]  DEAD_POS = POS_W'(DEAD);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{DIG_ACTIVE_LOW}};

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } phase_t;

    logic [POS_W-1:0]    pos;
    logic [IDX_W-1:0]    idx;

    logic [4*DIGITS-1:0] pend_value;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_lz;
    logic                pend_blink;

    logic [4*DIGITS-1:0] act_value;
    logic [DIGITS-1:0]   act_dp;
    logic                act_lz;
    logic                act_blink;

    logic                update_pending;
    logic                frame_tick;
    logic [BLK_W-1:0]    blink_cnt;
    phase_t              phase;

    logic [3:0]          nibble;
    logic                dp_bit;
    logic                blanked;
    logic                zeros_above;
    logic [DIGITS-1:0]   dig_sel;
    logic                in_dead;
    logic                lit;
    logic [6:0]          seg_next;
    logic                dp_next;
    logic [DIGITS-1:0]   dig_next;
    logic                frame_end;

    assign bus.update_pending = update_pending;
    assign bus.frame_tick     = frame_tick;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Walk digits from the top down so zeros_above covers nibbles i..DIGITS-1 at digit i.
    always_comb begin
        nibble      = 4'h0;
        dp_bit      = 1'b0;
        blanked     = 1'b0;
        zeros_above = 1'b1;
        dig_sel     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zeros_above = zeros_above && (act_value[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                nibble     = act_value[4*i +: 4];
                dp_bit     = act_dp[i];
                blanked    = act_lz && (i != 0) && zeros_above;
                dig_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        in_dead   = (pos < DEAD_POS);
        lit       = (phase == PHASE_ON);
        seg_next  = (in_dead || !lit || blanked) ? 7'h00 : hex_decode(nibble);
        dp_next   = !in_dead && lit && dp_bit;
        dig_next  = in_dead ? '0 : dig_sel;
        frame_end = (idx == IDX_LAST) && (pos == POS_LAST);
    end

    // Commit is evaluated before load so a load on the commit edge lands in the
    // freshly emptied pending buffer and keeps update_pending set.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pos            <= '0;
            idx            <= '0;
            pend_value     <= '0;
            pend_dp        <= '0;
            pend_lz        <= 1'b0;
            pend_blink     <= 1'b0;
            act_value      <= '0;
            act_dp         <= '0;
            act_lz         <= 1'b0;
            act_blink      <= 1'b0;
            update_pending <= 1'b0;
            blink_cnt      <= '0;
            phase          <= PHASE_ON;
            seg            <= SEG_OFF;
            seg_dp         <= DP_OFF;
            dig            <= DIG_OFF;
            frame_tick     <= 1'b0;
        end else begin
            seg        <= SEG_ACTIVE_LOW ? ~seg_next : seg_next;
            seg_dp     <= SEG_ACTIVE_LOW ? ~dp_next : dp_next;
            dig        <= DIG_ACTIVE_LOW ? ~dig_next : dig_next;
            frame_tick <= (pos == '0) && (idx == '0);

            if (pos == POS_LAST) begin
                pos <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pos <= pos + 1'b1;
            end

            if (frame_end) begin
                if (update_pending) begin
                    act_value      <= pend_value;
                    act_dp         <= pend_dp;
                    act_lz         <= pend_lz;
                    act_blink      <= pend_blink;
                    update_pending <= 1'b0;
                    blink_cnt      <= '0;
                    phase          <= PHASE_ON;
                end else if (act_blink) begin
                    if (blink_cnt == BLK_LAST) begin
                        blink_cnt <= '0;
                        phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end else begin
                    blink_cnt <= '0;
                    phase     <= PHASE_ON;
                end
            end

            if (bus.load) begin
                pend_value     <= bus.value;
                pend_dp        <= bus.dp;
                pend_lz        <= bus.lz_blank;
                pend_blink     <= bus.blink_en;
                update_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomised and directed bench for seg7_scan_mux against a frame-level reference model.
module tb_seg7_scan_mux;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 8;
    localparam int DEAD         = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic [6:0]        seg;
    logic              seg_dp;
    logic [DIGITS-1:0] dig;

    seg7_scan_mux_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_mux #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .DEAD(DEAD),
        .BLINK_FRAMES(BLINK_FRAMES),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus),
        .seg(seg),
        .seg_dp(seg_dp),
        .dig(dig)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: time since reset, buffers, and the frame of the last commit.
    int          t;
    int          commit_frame;
    logic [15:0] pend_value, act_value;
    logic [3:0]  pend_dp, act_dp;
    logic        pend_lz, act_lz, pend_blink, act_blink, pending;
    logic [6:0]  hex_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        t            = 0;
        commit_frame = -1;
        pend_value   = '0;
        act_value    = '0;
        pend_dp      = '0;
        act_dp       = '0;
        pend_lz      = 1'b0;
        act_lz       = 1'b0;
        pend_blink   = 1'b0;
        act_blink    = 1'b0;
        pending      = 1'b0;
    endtask

    task automatic applyReset(input int cycles, input logic ld);
        RST_N        = 1'b0;
        bus.load     = ld;
        bus.value    = 16'($urandom);
        bus.dp       = 4'($urandom);
        bus.lz_blank = 1'b1;
        bus.blink_en = 1'b1;
        repeat (cycles) begin
            @(posedge CLK);
            #1;
            checkOutput("reset dig", 32'(dig), 32'h0);
            checkOutput("reset seg", 32'(seg), 32'h7F);
            checkOutput("reset seg_dp", 32'(seg_dp), 32'h1);
            checkOutput("reset update_pending", 32'(bus.update_pending), 32'h0);
            checkOutput("reset frame_tick", 32'(bus.frame_tick), 32'h0);
        end
        RST_N    = 1'b1;
        bus.load = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, predict the registered outputs of the current counter state.
    task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic [3:0] dpv,
                                 input logic lz, input logic bl);
        int         pos, idx, frame, k;
        logic [6:0] e_seg;
        logic       e_dp, e_ft, lit, blanked;
        logic [3:0] e_dig, nib;

        bus.load     = ld;
        bus.value    = val;
        bus.dp       = dpv;
        bus.lz_blank = lz;
        bus.blink_en = bl;

        pos     = t % SCAN_DIV;
        idx     = (t / SCAN_DIV) % DIGITS;
        frame   = t / FRAME;
        k       = frame - commit_frame - 1;
        lit     = !act_blink || (((k / BLINK_FRAMES) % 2) == 0);
        blanked = act_lz && (idx >= 1) && ((act_value >> (4 * idx)) == 16'h0);
        nib     = act_value[4*idx +: 4];
        if (pos < DEAD) begin
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            e_dig = 4'h0;
        end else begin
            e_dig = 4'(1 << idx);
            e_seg = ~((lit && !blanked) ? hex_table[nib] : 7'h00);
            e_dp  = ~(lit && act_dp[idx]);
        end
        e_ft = (pos == 0) && (idx == 0);

        if (pos == SCAN_DIV - 1 && idx == DIGITS - 1 && pending) begin
            act_value    = pend_value;
            act_dp       = pend_dp;
            act_lz       = pend_lz;
            act_blink    = pend_blink;
            pending      = 1'b0;
            commit_frame = frame;
        end
        if (ld) begin
            pend_value = val;
            pend_dp    = dpv;
            pend_lz    = lz;
            pend_blink = bl;
            pending    = 1'b1;
        end

        @(posedge CLK);
        #1;
        checkOutput("dig", 32'(dig), 32'(e_dig));
        checkOutput("seg", 32'(seg), 32'(e_seg));
        checkOutput("seg_dp", 32'(seg_dp), 32'(e_dp));
        checkOutput("update_pending", 32'(bus.update_pending), 32'(pending));
        checkOutput("frame_tick", 32'(bus.frame_tick), 32'(e_ft));
        t++;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 16'($urandom), 4'($urandom), 1'($urandom_range(1)),
                                 1'($urandom_range(1)));
    endtask

    task automatic idle_until(input int ti, input int tp);
        while (!((t % SCAN_DIV) == tp && ((t / SCAN_DIV) % DIGITS) == ti)) idle(1);
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.dp       = '0;
        bus.lz_blank = 1'b0;
        bus.blink_en = 1'b0;
        model_reset();

        $display("[TB] reset with load held high");
        applyReset(5, 1'b1);
        idle(FRAME + 4);

        $display("[TB] decode and scan 12AF");
        applyStimulus(1'b1, 16'h12AF, 4'b0100, 1'b0, 1'b0);
        idle(3 * FRAME);

        $display("[TB] leading-zero blanking");
        applyStimulus(1'b1, 16'h0030, 4'b0000, 1'b1, 1'b0);
        idle(2 * FRAME);
        applyStimulus(1'b1, 16'h0000, 4'b1000, 1'b1, 1'b0);
        idle(2 * FRAME);

        $display("[TB] double-buffered loads");
        idle_until(1, 3);
        applyStimulus(1'b1, 16'h1111, 4'b0000, 1'b0, 1'b0);
        idle(5);
        applyStimulus(1'b1, 16'h2222, 4'b0000, 1'b0, 1'b0);
        idle(2 * FRAME);

        $display("[TB] blink");
        applyStimulus(1'b1, 16'h5A3C, 4'b1001, 1'b0, 1'b1);
        idle(6 * FRAME);
        idle_until(2, 4);
        applyStimulus(1'b1, 16'hBEEF, 4'b0010, 1'b0, 1'b1);
        idle(5 * FRAME);

        $display("[TB] mid-frame reset and coincident load");
        idle_until(2, 3);
        applyReset(1, 1'b1);
        idle(FRAME + 3);
        idle_until(DIGITS - 1, SCAN_DIV - 1);
        applyStimulus(1'b1, 16'h9876, 4'b0101, 1'b0, 1'b0);
        idle(3 * FRAME);

        $display("[TB] randomised traffic");
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(299) == 0) begin
                applyReset(1 + $urandom_range(2), 1'($urandom_range(1)));
            end else begin
                applyStimulus($urandom_range(24) == 0,
                              ($urandom_range(2) == 0) ? 16'($urandom_range(255)) : 16'($urandom),
                              4'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Parametrised, time-multiplexed 7-segment display driver for N-digit common-anode/common-cathode modules on the TinyFPGA BX. It latches a hex value with per-digit decimal points, scans one digit per time slot with dead-time ghosting suppression, and offers leading-zero blanking and frame-locked blink. Updates are double-buffered and commit only at a frame boundary, so the display never tears. The block sits between application logic and the board pins; the top level maps `seg`, `seg_dp` and `dig` to PIN_x.

## Interface
- `DIGITS`, 4: digit count, 1..8.
- `SCAN_DIV`, 4000: clock cycles per digit slot, ≥2. At 16 MHz, 4000 gives 4 kHz per slot.
- `DEAD`, 16: cycles at the start of each slot with all digits off, 0 ≤ DEAD < SCAN_DIV.
- `BLINK_FRAMES`, 256: frames per blink half-period, ≥1.
- `SEG_ACTIVE_LOW`, 1: 1 means segment pins are low when lit.
- `DIG_ACTIVE_LOW`, 0: 1 means digit pins are low when selected.

Ports:
- `CLK` in 1: single clock.
- `RST_N` in 1: reset, synchronous, active-low.
- `load` in 1: capture `value`, `dp`, `lz_blank` and `blink_en` into the pending buffer this cycle.
- `value` in 4*DIGITS: hex nibbles, with nibble i driving digit i (digit 0 is least significant).
- `dp` in DIGITS: decimal point per digit.
- `lz_blank` in 1: enable leading-zero blanking.
- `blink_en` in 1: enable blinking.
- `seg` out 7: segments, with bit0=a through bit6=g, in physical polarity.
- `seg_dp` out 1: decimal-point segment, in physical polarity.
- `dig` out DIGITS: digit enables, in physical polarity.
- `update_pending` out 1: pending buffer not yet committed.
- `frame_tick` out 1: one-cycle pulse at the first cycle of each frame.

## Operation
- **Counters.** `pos` counts 0..SCAN_DIV-1. `idx` increments when `pos` wraps, from 0..DIGITS-1 and wrapping to 0. A frame is DIGITS slots.
- **Registers.** Pending set: `value`, `dp`, `lz_blank`, `blink_en`. Active set: the same fields.
- **Load.** On `load`=1, write the pending set and set `update_pending`=1. A second load before commit overwrites the pending set; the last load wins.
- **Commit.** On the last cycle of a frame (`idx`=DIGITS-1, `pos`=SCAN_DIV-1), if `update_pending` is set:
  - copy pending to active;
  - clear `update_pending`;
  - reset the blink counter and phase to "on".
- **Load coincident with commit.**
  - If `update_pending` was 0, nothing commits and the new data commits at the next frame end.
  - If `update_pending` was 1, the old pending data commits, the new data is stored, and `update_pending` stays 1.
- **Decode (hex).** 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- **Leading-zero blanking.** When active `lz_blank`=1, digit i≥1 is blanked (segments off) if nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. A blanked digit still shows its `dp`.
- **Blink.** When active `blink_en`=1, the phase toggles every BLINK_FRAMES frames. In the "off" phase, `seg` and `seg_dp` are off while `dig` keeps scanning. When `blink_en`=0, the phase is held "on".
- **Slot output.**
  - `pos` < DEAD: all digits off, all segments off.
  - Otherwise: `dig` selects `idx` only, and `seg`/`seg_dp` carry the decode for nibble `idx` after blanking and blink.
- **Polarity.** If SEG_ACTIVE_LOW, invert `seg` and `seg_dp`. If DIG_ACTIVE_LOW, invert `dig`.

## Timing
- **Reset.** While `RST_N`=0 at a clock edge:
  - `pos`, `idx`, both register sets, `update_pending` and the blink counter clear to 0; phase = on;
  - `load` is ignored.
  - Outputs after that edge: `dig` and `seg`/`seg_dp` off in physical polarity; `update_pending`=0; `frame_tick`=0.
  - This applies in any state, including mid-frame or with a load pending.
- **First frame after reset.** `pos` = 0 on the first cycle after release, so the frame begins with slot 0 dead time.
- **Output latency.** `seg`, `seg_dp`, `dig` and `frame_tick` are registered: the outputs for counter state (`idx`, `pos`) appear one cycle later.
- **`update_pending` timing.** Rises one cycle after the `load` edge. Falls one cycle after the commit edge.
- **First committed digit.** Is shown in slot 0 of the next frame, at the first non-dead position plus one cycle of latency.
- **`frame_tick`.** High for one cycle, registered from `idx`=0 and `pos`=0.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=8, DEAD=2, BLINK_FRAMES=2, SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=0.
1. **Reset.** Hold `RST_N`=0 for 5 cycles with `load`=1 → `dig`=0000, `seg`=7F, `seg_dp`=1, `update_pending`=0, `frame_tick`=0. After release: first frame shows "0000", with `seg`=40 on each digit.
2. **Decode and scan.** Load `value`=12AF, `dp`=0100 → after commit, per slot: 2 dead cycles (`dig`=0000), then 6 cycles of:
   - `dig`=0001, `seg`=0E;
   - `dig`=0010, `seg`=08;
   - `dig`=0100, `seg`=24, `seg_dp`=0;
   - `dig`=1000, `seg`=79.
3. **Blanking.** Load `value`=0030 with `lz_blank`=1 → digits 3 and 2 show `seg`=7F, digit 1 shows 30, digit 0 shows 40. Then load `value`=0000 → only digit 0 lights, with `seg`=40.
4. **Double buffer.** Mid-frame, load 1111 then 2222 in the same frame → display unchanged until frame end, then shows "2222" (`seg`=24). `update_pending` is high from the first load+1 cycle until commit+1.
5. **Blink.** Load with `blink_en`=1 → 2 frames lit, then 2 frames with `seg`=7F while `dig` keeps scanning, repeating. A new load restarts the pattern with a lit phase.
6. **Mid-frame reset and coincident load.**
   - Drop `RST_N` during slot 2 → outputs off the next cycle, and the display returns to "0000" from frame start.
   - Assert `load` on the commit cycle with `update_pending`=0 → data appears one frame later.
